// File: rtl/data_bus_arbiter_if.sv
// Bus bundle between the requesters, the round-robin arbiter and the shared sink.
// The slave modport is the arbiter's view; master is the requester/sink side.
interface data_bus_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 2*(1+3)
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [SRC_W-1:0]              out_src;
    logic                          out_last;
    logic                          out_ready;

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_src, out_last
    );

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_src, out_last
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Round-robin packet arbiter: one requester owns the sink per grant (packet or
// MAX_BURST beats, whichever ends first), feeding a registered output stage.
module data_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 2*(1+3),
    parameter int MAX_BURST  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    data_bus_arbiter_if.slave bus
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state_q, state_d;
    logic [SRC_W-1:0]       owner_q, owner_d;
    logic [SRC_W-1:0]       last_owner_q, last_owner_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [SRC_W-1:0]       pick;
    logic                   pick_vld;
    logic [DATA_WIDTH-1:0]  beat [NUM_REQ];
    logic [NUM_REQ-1:0]     req_ready;
    logic                   accept_ok;
    logic                   xfer;
    logic                   eog;

    logic                   vld_p1;
    logic                   last_p1;
    logic [DATA_WIDTH-1:0]  data_p1;
    logic [SRC_W-1:0]       src_p1;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            beat[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        pick     = last_owner_q;
        pick_vld = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(last_owner_q) + k) % NUM_REQ;
            if (!pick_vld && bus.req_valid[idx]) begin
                pick     = SRC_W'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        accept_ok    = !vld_p1 || bus.out_ready;
        xfer         = (state_q == GRANT) && bus.req_valid[owner_q] && accept_ok;
        eog          = xfer && (bus.req_last[owner_q] || beat_cnt_q == CAP);
        req_ready    = '0;
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                req_ready[owner_q] = accept_ok;
                if (eog) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                    beat_cnt_d   = '0;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= SRC_W'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // p1: output register; a new beat may load in the same cycle the sink drains the old one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            data_p1 <= '0;
            src_p1  <= '0;
        end else if (xfer) begin
            vld_p1  <= 1'b1;
            last_p1 <= eog;
            data_p1 <= beat[owner_q];
            src_p1  <= owner_q;
        end else if (vld_p1 && bus.out_ready) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.out_valid = vld_p1;
    assign bus.out_last  = last_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_src   = src_p1;
endmodule
